// File: rtl/lcd_sign_if.sv
// LCD sign scanner bus: ROM read port plus the LCD RGB pins and frame marker.
interface lcd_sign_if #(
  parameter int unsigned ADDR_WIDTH = 17
) ();
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_data;
  logic                  lcd_hs;
  logic                  lcd_vs;
  logic                  lcd_de;
  logic [15:0]           lcd_rgb;
  logic                  frame_start;

  modport master (
    output rom_addr,
    output lcd_hs,
    output lcd_vs,
    output lcd_de,
    output lcd_rgb,
    output frame_start,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  lcd_hs,
    input  lcd_vs,
    input  lcd_de,
    input  lcd_rgb,
    input  frame_start,
    output rom_data
  );
endinterface

// File: rtl/lcd_sign_scanner.sv
// Raster timing generator and 1-bit bitmap pixel formatter for an RGB565 LCD.
// Optional blink of the sign window when LCD_SIGN_BLINK_EN is defined.
module lcd_sign_scanner #(
`ifdef LCD_SIGN_BLINK_EN
  parameter int unsigned BLINK_FRAMES = 30,
`endif
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned H_FP       = 2,
  parameter int unsigned H_SYNC     = 41,
  parameter int unsigned H_BP       = 2,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned V_FP       = 2,
  parameter int unsigned V_SYNC     = 10,
  parameter int unsigned V_BP       = 2,
  parameter int unsigned SIGN_X0    = 0,
  parameter int unsigned SIGN_Y0    = 0,
  parameter int unsigned SIGN_W     = 480,
  parameter int unsigned SIGN_H     = 272,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [15:0] FG_COLOR   = 16'hFFFF,
  parameter logic [15:0] BG_COLOR   = 16'h001F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  lcd_sign_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] HMax     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_SYNC);
  localparam logic [HW-1:0] HActBeg  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] HActEnd  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW-1:0] HWinBeg  = HW'(H_SYNC + H_BP + SIGN_X0);
  localparam logic [HW-1:0] HWinEnd  = HW'(H_SYNC + H_BP + SIGN_X0 + SIGN_W);
  localparam logic [VW-1:0] VMax     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_SYNC);
  localparam logic [VW-1:0] VActBeg  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] VActEnd  = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0] VWinBeg  = VW'(V_SYNC + V_BP + SIGN_Y0);
  localparam logic [VW-1:0] VWinEnd  = VW'(V_SYNC + V_BP + SIGN_Y0 + SIGN_H);

  // Pipeline stage layout: {frame_start, win, de, vs, hs}, syncs kept active-high
  localparam int unsigned PHs = 0, PVs = 1, PDe = 2, PWin = 3, PFs = 4;

  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_base;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [4:0]            s1_q, s1_d, s2_q, s2_d;
  logic                  hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0]           rgb_q, rgb_d;
  logic                  hs0, vs0, de0, win0, origin, frame_end, blink;

  always_comb begin
    hs0       = h_cnt_q < HSyncEnd;
    vs0       = v_cnt_q < VSyncEnd;
    de0       = (h_cnt_q >= HActBeg) && (h_cnt_q < HActEnd) &&
                (v_cnt_q >= VActBeg) && (v_cnt_q < VActEnd);
    win0      = de0 && (h_cnt_q >= HWinBeg) && (h_cnt_q < HWinEnd) &&
                (v_cnt_q >= VWinBeg) && (v_cnt_q < VWinEnd);
    origin    = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_end = en_i && (h_cnt_q == HMax) && (v_cnt_q == VMax);
    addr_base = origin ? '0 : addr_q;
  end

  always_comb begin
    h_cnt_d    = '0;
    v_cnt_d    = '0;
    addr_d     = '0;
    rom_addr_d = '0;
    s1_d       = '0;
    s2_d       = '0;
    hs_d       = 1'b1;
    vs_d       = 1'b1;
    de_d       = 1'b0;
    fs_d       = 1'b0;
    rgb_d      = 16'h0000;
    // en_i low flushes everything to reset values on the next edge
    if (en_i) begin
      h_cnt_d    = (h_cnt_q == HMax) ? '0 : h_cnt_q + HW'(1);
      v_cnt_d    = v_cnt_q;
      if (h_cnt_q == HMax) begin
        v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + VW'(1);
      end
      addr_d     = addr_base;
      rom_addr_d = rom_addr_q;
      if (win0) begin
        rom_addr_d = addr_base;
        addr_d     = addr_base + ADDR_WIDTH'(1);
      end
      s1_d  = {origin, win0, de0, vs0, hs0};
      s2_d  = s1_q;
      hs_d  = ~s2_q[PHs];
      vs_d  = ~s2_q[PVs];
      de_d  = s2_q[PDe];
      fs_d  = s2_q[PFs];
      // ROM data arrives alongside stage 2, so it pairs with s2_q here
      if (s2_q[PDe]) begin
        rgb_d = (s2_q[PWin] && bus.rom_data && !blink) ? FG_COLOR : BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      addr_q     <= '0;
      rom_addr_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      rgb_q      <= 16'h0000;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
    end
  end

`ifdef LCD_SIGN_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FLast = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  // Counting completed frames keeps the very first frame at phase 0
  always_comb begin
    fcnt_d  = '0;
    phase_d = 1'b0;
    if (en_i) begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (frame_end) begin
        if (fcnt_q == FLast) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink = phase_q;
`else
  assign blink = 1'b0;
`endif

  assign bus.rom_addr    = rom_addr_q;
  assign bus.lcd_hs      = hs_q;
  assign bus.lcd_vs      = vs_q;
  assign bus.lcd_de      = de_q;
  assign bus.lcd_rgb     = rgb_q;
  assign bus.frame_start = fs_q;

endmodule
